// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN core I/O blocks.
// Checksum trailer in bnn_result_tx is enabled by BNN_TX_CHECKSUM_EN.
package bnn_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_ARGMAX,
    TX_LOAD,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_t;

  localparam logic [3:0] BNN_HDR_MAGIC = 4'hA;
  localparam int         BNN_N_OUT     = 10;

  // Byte index must reach header + scores + trailer.
  function automatic int bnn_byte_w(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/bnn_sync2.sv
// Two-flop synchronizer with async active-low reset.
// Holds its state while ena is low.
module bnn_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else if (ena) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bnn_result_tx.sv
// BNN result transmitter: argmax + byte packet over valid/ack.
// Define BNN_TX_CHECKSUM_EN to append an XOR trailer byte.
module bnn_result_tx
  import bnn_pkg::*;
#(
  parameter int N_OUT   = BNN_N_OUT,
  parameter int SCORE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [N_OUT*SCORE_W-1:0] res_scores,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ack,
  output logic                     busy
);

  localparam int BW = bnn_byte_w(N_OUT);
  localparam int IW = $clog2(N_OUT);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);
`ifdef BNN_TX_CHECKSUM_EN
  localparam logic [BW-1:0] LAST_B = BW'(N_OUT + 1);
`else
  localparam logic [BW-1:0] LAST_B = BW'(N_OUT);
`endif

  tx_state_t          state;
  logic [SCORE_W-1:0] sc [N_OUT];
  logic [SCORE_W-1:0] best;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      cls;
  logic [BW-1:0]      bidx;
  logic [7:0]         cur;
  logic               ack_s;
`ifdef BNN_TX_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  bnn_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .d     (tx_ack),
    .q     (ack_s)
  );

  always_comb begin
    cur = {BNN_HDR_MAGIC, 4'(cls)};
`ifdef BNN_TX_CHECKSUM_EN
    if (bidx == LAST_B)
      cur = csum;
    else if (bidx != '0)
      cur = sc[IW'(bidx - 1'b1)];
`else
    if (bidx != '0)
      cur = sc[IW'(bidx - 1'b1)];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TX_IDLE;
      for (int i = 0; i < N_OUT; i++)
        sc[i] <= '0;
      best      <= '0;
      idx       <= '0;
      cls       <= '0;
      bidx      <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      res_ready <= 1'b1;
      busy      <= 1'b0;
`ifdef BNN_TX_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else if (ena) begin
      unique case (state)
        TX_IDLE: begin
          if (res_valid) begin
            for (int i = 0; i < N_OUT; i++)
              sc[i] <= res_scores[i*SCORE_W +: SCORE_W];
            idx       <= '0;
            best      <= '0;
            cls       <= '0;
            res_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= TX_ARGMAX;
          end
        end
        TX_ARGMAX: begin
          // Strict compare keeps the lowest index on ties.
          if (sc[idx] > best) begin
            best <= sc[idx];
            cls  <= idx;
          end
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            bidx  <= '0;
`ifdef BNN_TX_CHECKSUM_EN
            csum  <= 8'h00;
`endif
            state <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          tx_data  <= cur;
          tx_valid <= 1'b1;
`ifdef BNN_TX_CHECKSUM_EN
          csum     <= csum ^ cur;
`endif
          state    <= TX_WAIT_HI;
        end
        TX_WAIT_HI: begin
          if (ack_s) begin
            tx_valid <= 1'b0;
            state    <= TX_WAIT_LO;
          end
        end
        TX_WAIT_LO: begin
          if (!ack_s) begin
            if (bidx == LAST_B) begin
              busy      <= 1'b0;
              res_ready <= 1'b1;
              state     <= TX_IDLE;
            end else begin
              bidx  <= bidx + 1'b1;
              state <= TX_LOAD;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule
